// File: rtl/nios_system_sysid_checker_pkg.sv
// sysid_checker_pkg: shared FSM state type and constants for the sysid checker
package sysid_checker_pkg;
    typedef enum logic [1:0] {IDLE, RD_ID, RD_TS, DONE} state_t;
    localparam logic SYSID_ADDR_ID = 1'b0;
    localparam logic SYSID_ADDR_TS = 1'b1;
    localparam int unsigned STALL_CNT_W = 16;
endpackage

// File: rtl/nios_system_sysid_checker_if.sv
// nios_system_sysid_checker_if: Avalon-MM read port between checker and sysid slave
interface nios_system_sysid_checker_if;
    logic        avm_address;
    logic        avm_read;
    logic [31:0] avm_readdata;
    logic        avm_waitrequest;
    modport master (output avm_address, avm_read, input avm_readdata, avm_waitrequest);
    modport slave  (input avm_address, avm_read, output avm_readdata, avm_waitrequest);
endinterface

// File: rtl/nios_system_sysid_checker_stall_timer.sv
// sysid_stall_timer: counts consecutive stalled cycles of one read phase and flags expiry
module sysid_stall_timer
    import sysid_checker_pkg::*;
#(
    parameter int unsigned LIMIT = 256
) (
    input  logic clock,
    input  logic reset_n,
    input  logic clear_i,
    input  logic inc_i,
    output logic expired_o
);
    logic [STALL_CNT_W-1:0] cnt_q, cnt_d;

    // next count: restart on phase entry, step on each stalled cycle
    always_comb cnt_d = clear_i ? '0 : inc_i ? cnt_q + 1'b1 : cnt_q;

    // stall counter register
    always_ff @(posedge clock or negedge reset_n)
        if (!reset_n) cnt_q <= '0;
        else cnt_q <= cnt_d;

    // expire on the edge that ends the LIMIT-th stalled cycle
    assign expired_o = inc_i && (cnt_q == STALL_CNT_W'(LIMIT - 1));
endmodule

// File: rtl/nios_system_sysid_checker.sv
// nios_system_sysid_checker: reads sysid ID/timestamp after reset or on recheck and
// reports match status; SYSID_CHECK_TIMEOUT_EN adds a per-read stall abort
module nios_system_sysid_checker
    import sysid_checker_pkg::*;
#(
    parameter logic [31:0] EXPECTED_ID        = 32'd0,
    parameter logic [31:0] EXPECTED_TIMESTAMP = 32'd1445410163,
    parameter int unsigned TIMEOUT_CYCLES     = 256
) (
    input  logic                               clock,
    input  logic                               reset_n,
    input  logic                               recheck,
    nios_system_sysid_checker_if.master        avm,
    output logic                               busy,
    output logic                               done,
    output logic                               done_pulse,
    output logic                               id_ok,
    output logic                               ts_ok,
    output logic                               pass,
    output logic                               timeout,
    output logic [31:0]                        id_value,
    output logic [31:0]                        ts_value
);
    if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 65535) begin : g_bad_timeout
        $error("TIMEOUT_CYCLES must be in 1..65535");
    end

    state_t      state_q;
    logic        addr_q, read_q, done_q, pulse_q, id_ok_q, ts_ok_q, timeout_q;
    logic [31:0] id_value_q, ts_value_q;
    logic        expired;

    assign busy = (state_q == RD_ID) || (state_q == RD_TS);

`ifdef SYSID_CHECK_TIMEOUT_EN
    logic stall;
    assign stall = busy && avm.avm_waitrequest;
    sysid_stall_timer #(.LIMIT(TIMEOUT_CYCLES)) u_timer (
        .clock     (clock),
        .reset_n   (reset_n),
        .clear_i   (!stall),
        .inc_i     (stall),
        .expired_o (expired)
    );
`else
    assign expired = 1'b0;
`endif

    // sequencer: auto-start once per reset, two zero-latency reads, then wait for recheck
    always_ff @(posedge clock or negedge reset_n)
        if (!reset_n) begin
            state_q    <= IDLE;
            addr_q     <= SYSID_ADDR_ID;
            read_q     <= 1'b0;
            done_q     <= 1'b0;
            pulse_q    <= 1'b0;
            id_ok_q    <= 1'b0;
            ts_ok_q    <= 1'b0;
            timeout_q  <= 1'b0;
            id_value_q <= '0;
            ts_value_q <= '0;
        end else begin
            pulse_q <= 1'b0;
            if (busy && expired) begin
                state_q   <= DONE;
                addr_q    <= SYSID_ADDR_ID;
                read_q    <= 1'b0;
                done_q    <= 1'b1;
                pulse_q   <= 1'b1;
                id_ok_q   <= 1'b0;
                ts_ok_q   <= 1'b0;
                timeout_q <= 1'b1;
            end else begin
                case (state_q)
                    IDLE: begin
                        state_q <= RD_ID;
                        addr_q  <= SYSID_ADDR_ID;
                        read_q  <= 1'b1;
                    end
                    RD_ID: if (!avm.avm_waitrequest) begin
                        id_value_q <= avm.avm_readdata;
                        state_q    <= RD_TS;
                        addr_q     <= SYSID_ADDR_TS;
                    end
                    RD_TS: if (!avm.avm_waitrequest) begin
                        ts_value_q <= avm.avm_readdata;
                        state_q    <= DONE;
                        addr_q     <= SYSID_ADDR_ID;
                        read_q     <= 1'b0;
                        done_q     <= 1'b1;
                        pulse_q    <= 1'b1;
                        id_ok_q    <= id_value_q == EXPECTED_ID;
                        ts_ok_q    <= avm.avm_readdata == EXPECTED_TIMESTAMP;
                    end
                    DONE: if (recheck) begin
                        state_q   <= RD_ID;
                        addr_q    <= SYSID_ADDR_ID;
                        read_q    <= 1'b1;
                        done_q    <= 1'b0;
                        id_ok_q   <= 1'b0;
                        ts_ok_q   <= 1'b0;
                        timeout_q <= 1'b0;
                    end
                    default: state_q <= IDLE;
                endcase
            end
        end

    assign avm.avm_address = addr_q;
    assign avm.avm_read    = read_q;
    assign done            = done_q;
    assign done_pulse      = pulse_q;
    assign id_ok           = id_ok_q;
    assign ts_ok           = ts_ok_q;
    assign pass            = id_ok_q & ts_ok_q;
    assign timeout         = timeout_q;
    assign id_value        = id_value_q;
    assign ts_value        = ts_value_q;
endmodule
